// File: rtl/vga_frame_driver.sv
// vga_frame_driver: 640x480@60 Hz raster timing, paced animation strobe and
// TinyTapeout VGA PMOD packing for the WatPixels pattern interface.
// Build option: define OUTPUT_REG_EN to register vga_out_o (one cycle latency).
module vga_frame_driver #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed_i,
   input  logic       pause_i,
   input  logic [5:0] rgb_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       active_o,
   output logic       next_frame_o,
   output logic [7:0] vga_out_o
);

   localparam logic [9:0] HActive    = 10'(H_ACTIVE);
   localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VActive    = 10'(V_ACTIVE);
   localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic [2:0] div_q, div_d;
   logic [2:0] div_thr;
   logic       eligible;
   logic       hsync_n, vsync_n;
   logic [5:0] colour;
   logic [7:0] vga_comb;

   // Raster counters: h wraps every line, v advances on each h wrap.
   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == HLast) begin
         h_d = 10'd0;
         v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
      end
   end

   // Frame divider: threshold is 2^speed - 1, evaluated only on the first blanking line.
   always_comb begin
      div_thr = 3'd0;
      unique case (speed_i)
         2'd0: div_thr = 3'd0;
         2'd1: div_thr = 3'd1;
         2'd2: div_thr = 3'd3;
         2'd3: div_thr = 3'd7;
         default: div_thr = 3'd0;
      endcase
      eligible     = (h_q == 10'd0) && (v_q == VActive);
      next_frame_o = 1'b0;
      div_d        = div_q;
      if (eligible && !pause_i) begin
         if (div_q >= div_thr) begin
            next_frame_o = 1'b1;
            div_d        = 3'd0;
         end else begin
            div_d = div_q + 3'd1;
         end
      end
   end

   // Counter and divider state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q   <= 10'd0;
         v_q   <= 10'd0;
         div_q <= 3'd0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         div_q <= div_d;
      end
   end

   // Coordinates, active window, active-low syncs and blanked colour packing.
   always_comb begin
      x_o      = h_q;
      y_o      = v_q;
      active_o = (h_q < HActive) && (v_q < VActive);
      hsync_n  = !((h_q >= HSyncStart) && (h_q <= HSyncEnd));
      vsync_n  = !((v_q >= VSyncStart) && (v_q <= VSyncEnd));
      colour   = active_o ? rgb_i : 6'd0;
      // rgb_i is {R1,G1,B1,R0,G0,B0}; bus is {hsync,B0,G0,R0,vsync,B1,G1,R1}.
      vga_comb = {hsync_n, colour[0], colour[1], colour[2],
                  vsync_n, colour[3], colour[4], colour[5]};
   end

`ifdef OUTPUT_REG_EN
   logic [7:0] vga_q;

   // Registered bus: sync and colour of one counter cycle move together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_q <= 8'b1000_1000;
      end else begin
         vga_q <= vga_comb;
      end
   end

   assign vga_out_o = vga_q;
`else
   assign vga_out_o = vga_comb;
`endif

endmodule
